// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state type, default depth and byte-order helper for prog_loader
`ifndef BITNESS
`define BITNESS 32
`endif

package prog_loader_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } loader_state_t;

  localparam int DEFAULT_DEPTH = 1024;

  function automatic logic [31:0] le_word(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte load stream handshake between image source and prog_loader
interface prog_loader_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/prog_ram.sv
// rtl/prog_ram.sv - program byte RAM: one write port, six wrapping async read ports masked by len
module prog_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [7:0]       wdata,
  input  logic [AW:0]      len,
  input  logic [AW-1:0]    raddr,
  output logic [5:0][7:0]  rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Bytes at or beyond len read as zero so a shorter reload never exposes stale image data.
  for (genvar i = 0; i < 6; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a        = raddr + AW'(i);
    assign rdata[i] = ({1'b0, a} < len) ? mem[a] : 8'h00;
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - program image loader and instruction/imm fetch front end for processor
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  prog_loader_if.slave        ld,
  input  logic                reload,
  output logic                core_rst,
  input  logic [`BITNESS-1:0] pc,
  output logic [15:0]         instruction,
  output logic [31:0]         imm,
  output logic [AW:0]         len,
  output logic                err
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  loader_state_t   state;
  logic [AW:0]     ptr;
  logic [AW:0]     ptr_inc;
  logic [AW:0]     len_last;
  logic            hs;
  logic            in_range;
  logic            data_byte;
  logic            csum_bad;
  logic            wr_en;
  logic            err_nxt;
  logic [5:0][7:0] rd;
  logic            unused_pc_hi;

  assign ld.s_ready = (state == LOAD);
  assign hs         = ld.s_valid && ld.s_ready;
  assign in_range   = ptr < DEPTH_W;
  assign ptr_inc    = in_range ? ptr + ONE : ptr;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  assign data_byte = !ld.s_last;
  assign csum_bad  = 8'(sum + ld.s_data) != 8'h00;
  assign len_last  = ptr;
`else
  assign data_byte = 1'b1;
  assign csum_bad  = 1'b0;
  assign len_last  = ptr_inc;
`endif

  assign wr_en   = hs && data_byte && in_range;
  assign err_nxt = err || (data_byte && !in_range) || (ld.s_last && csum_bad);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOAD;
      ptr      <= '0;
      len      <= '0;
      err      <= 1'b0;
      core_rst <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else if (reload && state != LOAD) begin
      // Core is put back in reset on the same edge the new load begins.
      state    <= LOAD;
      ptr      <= '0;
      err      <= 1'b0;
      core_rst <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      core_rst <= (state != RUN);
      if (hs) begin
        ptr <= ptr_inc;
        err <= err_nxt;
`ifdef LOADER_CHECKSUM_EN
        sum <= sum + ld.s_data;
`endif
        if (ld.s_last) begin
          len   <= len_last;
          state <= err_nxt ? HALT : RUN;
        end
      end
    end
  end

  prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (ptr[AW-1:0]),
    .wdata (ld.s_data),
    .len   (len),
    .raddr (pc[AW-1:0]),
    .rdata (rd)
  );

  assign instruction  = {rd[1], rd[0]};
  assign imm          = le_word(rd[2], rd[3], rd[4], rd[5]);
  assign unused_pc_hi = ^pc[`BITNESS-1:AW];

endmodule
